mem_port_arbiter: RTL and testbench

//   Shares one unified memory port between the IF stage (instruction fetch) and the MEM

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around mem_port_arbiter.
// The arbiter uses the slave view; the datapath/memory environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [3:0]      m_wstrb;
    logic            m_ready;
    logic            m_rvalid;
    logic [XLEN-1:0] m_rdata;

    logic            stall_if;
    logic            stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_ready, m_rvalid, m_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_ready, m_rvalid, m_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define ARB_PERF_EN to add the conflict_cnt performance counter output.
module mem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_port_arbiter_if.slave        bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]              conflict_cnt
`endif
);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_d;
    logic              owner_d_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_cnt_nxt;
    logic              d_win;
    logic              i_win;

    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        wstrb_q;

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner_d    <= owner_d_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Arbitration, handshake sequencing and response routing
    always_comb begin : next_state
        state_nxt      = state;
        owner_d_nxt    = owner_d;
        starve_cnt_nxt = starve_cnt;
        d_win          = 1'b0;
        i_win          = 1'b0;
        bus.if_gnt     = 1'b0;
        bus.d_gnt      = 1'b0;
        bus.if_rvalid  = 1'b0;
        bus.d_rvalid   = 1'b0;

        unique case (state)
            IDLE: begin
                // Data normally wins, unless it has already starved a waiting fetch
                d_win      = bus.d_req & ((starve_cnt < CNT_W'(STARVE_MAX)) | ~bus.if_req);
                i_win      = ~d_win & bus.if_req;
                bus.d_gnt  = d_win;
                bus.if_gnt = i_win;
                if (d_win | i_win) begin
                    state_nxt   = REQ;
                    owner_d_nxt = d_win;
                end
                if (~bus.if_req | i_win) begin
                    starve_cnt_nxt = '0;
                end else if (d_win && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end
            REQ: begin
                if (bus.m_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.m_rvalid) begin
                    bus.if_rvalid = ~owner_d;
                    bus.d_rvalid  = owner_d;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request and payload registers; payload frozen from grant to acceptance
    always_ff @(posedge clk) begin : payload_reg
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            req_q <= (state_nxt == REQ);
            if (d_win) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                wstrb_q <= bus.d_wstrb;
            end else if (i_win) begin
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wstrb_q <= '0;
            end
        end
    end

    assign bus.m_req     = req_q;
    assign bus.m_we      = we_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;

    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_rdata   = bus.m_rdata;
    assign bus.stall_if  = bus.if_req & ~bus.if_rvalid;
    assign bus.stall_mem = bus.d_req & ~bus.d_rvalid;

`ifdef ARB_PERF_EN
    // Counts idle cycles where both stages compete for the port
    always_ff @(posedge clk) begin : conflict_reg
        if (reset) begin
            conflict_cnt <= '0;
        end else if ((state == IDLE) && bus.if_req && bus.d_req) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: agents issue fetch/data requests, a memory model
// answers, and a negedge monitor checks grants, memory payloads and routed responses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          TIMEOUT    = 400;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mtxn_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus ();
`ifdef ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // memory model knobs
    int rdy_pct   = 100;
    int lat_lo    = 0;
    int lat_hi    = 0;
    int force_low = 0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mtxn_t exp_m  [$];
    resp_t exp_if [$];
    resp_t exp_d  [$];
    bit    gnt_log[$];

    int f_rv_cnt    = 0;
    int d_rv_cnt    = 0;
    int acc_cnt     = 0;
    int dgnt_cnt    = 0;
    int mreq_cycles = 0;
    int conf_model  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // External memory: random ready, random completion latency, byte-strobed writes
    initial begin : memory
        bit          pend;
        int          wait_n;
        logic [31:0] hold;
        logic [31:0] cur;
        logic [31:0] mask;
        pend   = 1'b0;
        wait_n = 0;
        hold   = '0;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.m_req === 1'b1) begin
                if (bus.m_ready) begin
                    cur = mem_arr.exists(bus.m_addr) ? mem_arr[bus.m_addr] : init_val(bus.m_addr);
                    if (bus.m_we) begin
                        mask = {{8{bus.m_wstrb[3]}}, {8{bus.m_wstrb[2]}},
                                {8{bus.m_wstrb[1]}}, {8{bus.m_wstrb[0]}}};
                        mem_arr[bus.m_addr] = (cur & ~mask) | (bus.m_wdata & mask);
                    end
                    hold   = cur;
                    pend   = 1'b1;
                    wait_n = $urandom_range(lat_hi, lat_lo);
                end
                if (force_low > 0) force_low--;
            end
            @(posedge clk);
            #1;
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = $urandom;
            if (pend) begin
                if (wait_n == 0) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = hold;
                    pend         = 1'b0;
                end else begin
                    wait_n--;
                end
            end
            bus.m_ready = (force_low == 0) && (int'($urandom_range(99, 0)) < rdy_pct);
        end
    end

    // Transaction-level model of the port: who must win, when m_req must show, who gets the reply
    initial begin : monitor
        bit    busy, req_ph, resp_ph, own_d;
        bit    dw, fw, exp_irv, exp_drv;
        int    starve;
        mtxn_t m_exp;
        resp_t r;
        busy = 0; req_ph = 0; resp_ph = 0; own_d = 0; starve = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                busy = 0; req_ph = 0; resp_ph = 0; own_d = 0; starve = 0;
                conf_model = 0;
                exp_m.delete();
                exp_if.delete();
                exp_d.delete();
                continue;
            end
            dw = 0;
            fw = 0;
            if (!busy) begin
                dw = bus.d_req && ((starve < STARVE_MAX) || !bus.if_req);
                fw = !dw && bus.if_req;
                if (bus.if_req && bus.d_req) conf_model++;
            end
            chk1("if_gnt", bus.if_gnt, fw);
            chk1("d_gnt", bus.d_gnt, dw);
            chk1("m_req", bus.m_req, req_ph);

            if (req_ph) begin
                if (exp_m.size() == 0) begin
                    fail("m_payload_unexpected");
                end else begin
                    m_exp = exp_m[0];
                    chk1("m_we", bus.m_we, m_exp.we);
                    chk("m_addr", bus.m_addr, m_exp.addr);
                    chk("m_wstrb", 32'(bus.m_wstrb), 32'(m_exp.wstrb));
                    if (m_exp.we) chk("m_wdata", bus.m_wdata, m_exp.wdata);
                    if (bus.m_ready) void'(exp_m.pop_front());
                end
            end

            exp_irv = resp_ph && !own_d && bus.m_rvalid;
            exp_drv = resp_ph && own_d && bus.m_rvalid;
            chk1("if_rvalid", bus.if_rvalid, exp_irv);
            chk1("d_rvalid", bus.d_rvalid, exp_drv);
            if (exp_irv && bus.if_rvalid) begin
                if (exp_if.size() == 0) fail("if_resp_unexpected");
                else begin
                    r = exp_if.pop_front();
                    if (r.chk) chk("if_rdata", bus.if_rdata, r.data);
                end
            end
            if (exp_drv && bus.d_rvalid) begin
                if (exp_d.size() == 0) fail("d_resp_unexpected");
                else begin
                    r = exp_d.pop_front();
                    if (r.chk) chk("d_rdata", bus.d_rdata, r.data);
                end
            end
            chk1("stall_if", bus.stall_if, bus.if_req && !exp_irv);
            chk1("stall_mem", bus.stall_mem, bus.d_req && !exp_drv);

            // event counters for the stimulus side
            if (bus.m_req) mreq_cycles++;
            if (bus.if_gnt || bus.d_gnt) begin
                gnt_log.push_back(bus.d_gnt);
                mreq_cycles = 0;
            end
            if (bus.d_gnt) dgnt_cnt++;
            if (bus.if_rvalid) f_rv_cnt++;
            if (bus.d_rvalid) d_rv_cnt++;
            if (bus.m_req && bus.m_ready) acc_cnt++;

            // advance the model
            if (resp_ph && bus.m_rvalid) begin
                resp_ph = 0;
                busy    = 0;
            end
            if (req_ph && bus.m_ready) begin
                req_ph  = 0;
                resp_ph = 1;
            end
            if (dw || fw) begin
                busy   = 1;
                req_ph = 1;
                own_d  = dw;
                if (dw) exp_m.push_back('{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, wstrb: bus.d_wstrb});
                else    exp_m.push_back('{we: 1'b0, addr: bus.if_addr, wdata: 32'h0, wstrb: 4'h0});
            end
            if (dw && bus.if_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
            else if (fw || !bus.if_req) starve = 0;
        end
    end

    task automatic fetch_txn(input logic [31:0] a, input int gap);
        int base;
        int n;
        base = f_rv_cnt;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        exp_if.push_back('{chk: 1'b1, data: init_val(a)});
        n = 0;
        while (f_rv_cnt == base && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("if_resp_seen", f_rv_cnt != base, 1'b1);
        bus.if_req = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, input int gap);
        int          base;
        int          n;
        logic [31:0] cur;
        base = d_rv_cnt;
        cur  = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
            end
            ref_mem[a] = cur;
            exp_d.push_back('{chk: 1'b0, data: 32'h0});
        end else begin
            exp_d.push_back('{chk: 1'b1, data: cur});
        end
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_wstrb = s;
        n = 0;
        while (d_rv_cnt == base && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("d_resp_seen", d_rv_cnt != base, 1'b1);
        bus.d_req = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : main
        int base;
        int n;
        bit exp_seq [7];
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk1("rst_m_req", bus.m_req, 1'b0);
        chk1("rst_m_we", bus.m_we, 1'b0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
        chk("rst_m_wstrb", 32'(bus.m_wstrb), 32'h0);
`ifdef ARB_PERF_EN
        chk("rst_conflict_cnt", conflict_cnt, 32'h0);
`endif

        // single fetch, minimum latency
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        exp_if.push_back('{chk: 1'b1, data: 32'h0000_0013});
        @(negedge clk);
        chk1("c0_if_gnt", bus.if_gnt, 1'b1);
        chk1("c0_stall_if", bus.stall_if, 1'b1);
        @(negedge clk);
        chk1("c1_m_req", bus.m_req, 1'b1);
        chk("c1_m_addr", bus.m_addr, 32'h100);
        chk1("c1_stall_if", bus.stall_if, 1'b1);
        @(negedge clk);
        chk1("c2_if_rvalid", bus.if_rvalid, 1'b1);
        chk("c2_if_rdata", bus.if_rdata, 32'h0000_0013);
        chk1("c2_stall_if", bus.stall_if, 1'b0);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;

        // simultaneous requests: data first
        base = gnt_log.size();
        fork
            fetch_txn(32'h104, 0);
            data_txn(1'b0, 32'h2000, 32'h0, 4'h0, 0);
        join
        if (gnt_log.size() >= base + 2) begin
            chk1("both_first_is_data", gnt_log[base], 1'b1);
            chk1("both_second_is_fetch", gnt_log[base+1], 1'b0);
        end else fail("both_grant_count");

        // continuous data traffic against a waiting fetch
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        base = gnt_log.size();
        fork
            begin
                for (int i = 0; i < 6; i++) data_txn(1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'h0, 0);
            end
            fetch_txn(32'h108, 0);
        join
        if (gnt_log.size() >= base + 7) begin
            for (int i = 0; i < 7; i++) chk1("starve_order", gnt_log[base+i], exp_seq[i]);
        end else fail("starve_grant_count");

        // store held off by memory for three cycles
        force_low = 3;
        base = dgnt_cnt;
        data_txn(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 0);
        chk("store_m_req_cycles", 32'(mreq_cycles), 32'd4);
        chk("store_d_gnt_pulses", 32'(dgnt_cnt - base), 32'd1);
        data_txn(1'b0, 32'h200, 32'h0, 4'h0, 1);

        // reset while waiting for the response; the late completion must vanish
        lat_lo = 2;
        lat_hi = 2;
        base = acc_cnt;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10C;
        n = 0;
        while (acc_cnt == base && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk1("rr_accepted", acc_cnt != base, 1'b1);
        base = f_rv_cnt;
        reset = 1'b1;
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("rr_m_req_after", bus.m_req, 1'b0);
        @(negedge clk);
        chk1("rr_late_if_rvalid", bus.if_rvalid, 1'b0);
        chk1("rr_late_d_rvalid", bus.d_rvalid, 1'b0);
        chk1("rr_m_req_late", bus.m_req, 1'b0);
        chk("rr_no_resp_count", 32'(f_rv_cnt - base), 32'd0);
        @(posedge clk);
        #1;
        lat_lo = 0;
        lat_hi = 0;
        fetch_txn(32'h110, 1);

        // randomized mixed traffic
        rdy_pct = 70;
        lat_lo  = 0;
        lat_hi  = 3;
        fork
            begin
                for (int i = 0; i < 120; i++)
                    fetch_txn(32'h1000 + 32'($urandom_range(255, 0) * 4), int'($urandom_range(3, 0)));
            end
            begin
                for (int i = 0; i < 120; i++)
                    data_txn(1'($urandom_range(1, 0)), 32'h3000 + 32'($urandom_range(15, 0) * 4),
                             $urandom, 4'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 32'(exp_m.size() + exp_if.size() + exp_d.size()), 32'd0);

`ifdef ARB_PERF_EN
        @(negedge clk);
        chk("conflict_cnt", conflict_cnt, 32'(conf_model));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("conflict_cnt_reset", conflict_cnt, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
